// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control sequencer.
// Fetch, decode, exec, mem, writeback; owns PC and IR.
module mc_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_pc,
  output logic        o_imem_req,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [5:0]  o_format,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_valid,
  input  logic [31:0] i_next_pc,
  output logic        o_rd_we,
  output logic        o_retire,
  output logic        o_halt,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM,
    S_WB, S_HALT, S_TRAP
  } state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] ONE = 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_FENC = 7'b0001111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;
  logic [5:0]    dec_fmt;
  logic          dec_halt;
  logic          dec_ill;
  logic          waiting;
  logic          expired;
  logic          aligned;
  logic          is_load;
  logic          is_store;
  logic [1:0]    cause;
  logic [6:0]    op;

  assign op       = o_inst[6:0];
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_ST);
  assign aligned  = (i_next_pc[1:0] == 2'b00);

  assign waiting =
    ((state == S_FETCH) && !i_imem_valid) ||
    ((state == S_MEM) && !i_dmem_valid);

  assign expired = (TIMEOUT_CYCLES != 0) && waiting &&
    ((32'(cnt) + 32'd1) >= TIMEOUT_CYCLES);

  // Opcode classification into the one-hot format vector
  always_comb begin
    dec_fmt  = 6'b000000;
    dec_halt = 1'b0;
    dec_ill  = 1'b0;
    unique case (1'b1)
      op == OP_R:    dec_fmt = 6'b000001;
      op == OP_IMM,
      op == OP_LOAD,
      op == OP_JALR,
      op == OP_FENC: dec_fmt = 6'b000010;
      op == OP_ST:   dec_fmt = 6'b000100;
      op == OP_BR:   dec_fmt = 6'b001000;
      op == OP_LUI,
      op == OP_AUI:  dec_fmt = 6'b010000;
      op == OP_JAL:  dec_fmt = 6'b100000;
      op == OP_SYS:  dec_halt = 1'b1;
      default:       dec_ill = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_FETCH;
    else          state <= next;
  end

  // Next-state logic
  always_comb begin
    next  = state;
    cause = 2'd0;
    unique case (state)
      S_FETCH: begin
        cause = 2'd1;
        if (i_imem_valid) next = S_DECODE;
        else if (expired) next = S_TRAP;
      end
      S_DECODE: begin
        cause = 2'd0;
        if (dec_halt)     next = S_HALT;
        else if (dec_ill) next = S_TRAP;
        else              next = S_EXEC;
      end
      S_EXEC: begin
        if (is_load || is_store) next = S_MEM;
        else                     next = S_WB;
      end
      S_MEM: begin
        cause = 2'd2;
        if (i_dmem_valid) next = S_WB;
        else if (expired) next = S_TRAP;
      end
      S_WB: begin
        cause = 2'd3;
        if (aligned) next = S_FETCH;
        else         next = S_TRAP;
      end
      default: next = state;
    endcase
  end

  // Moore strobes; WB commit also qualified by PC alignment
  always_comb begin
    o_imem_req = (state == S_FETCH);
    o_dmem_req = (state == S_MEM);
    o_dmem_we  = (state == S_MEM) && is_store;
    o_retire   = (state == S_WB) && aligned;
    o_rd_we    = (state == S_WB) && aligned &&
                 (o_format[0] || o_format[1] ||
                  o_format[4] || o_format[5]);
  end

  // Wait counter: runs only while stalled on a request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        cnt <= '0;
    else if (!waiting)   cnt <= '0;
    else if (cnt != '1)  cnt <= cnt + ONE;
  end

  // PC, instruction and format registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc     <= RESET_PC;
      o_inst   <= '0;
      o_format <= '0;
    end else begin
      if (state == S_FETCH && i_imem_valid)
        o_inst <= i_imem_rdata;
      if (state == S_DECODE)
        o_format <= dec_fmt;
      if (state == S_WB && aligned)
        o_pc <= i_next_pc;
    end
  end

  // Sticky halt / trap flags and trap cause
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_halt       <= 1'b0;
      o_trap       <= 1'b0;
      o_trap_cause <= 2'd0;
    end else begin
      if (next == S_HALT && state != S_HALT)
        o_halt <= 1'b1;
      if (next == S_TRAP && state != S_TRAP) begin
        o_trap       <= 1'b1;
        o_trap_cause <= cause;
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for mc_ctrl.
// Expected values hand-computed from the sequencer behaviour.
module tb_mc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  format;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_valid;
  logic [31:0] next_pc;
  logic        rd_we;
  logic        retire;
  logic        halt;
  logic        trap;
  logic [1:0]  trap_cause;

  int total;
  int passed;

  mc_ctrl #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .o_pc(pc),
    .o_imem_req(imem_req),
    .i_imem_valid(imem_valid),
    .i_imem_rdata(imem_rdata),
    .o_inst(inst),
    .o_format(format),
    .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we),
    .i_dmem_valid(dmem_valid),
    .i_next_pc(next_pc),
    .o_rd_we(rd_we),
    .o_retire(retire),
    .o_halt(halt),
    .o_trap(trap),
    .o_trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    dmem_valid = 1'b0;
    next_pc    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one instruction for one cycle; leaves DUT in DECODE
  task automatic fetch(input logic [31:0] w);
    imem_valid = 1'b1;
    imem_rdata = w;
    tick();
    imem_valid = 1'b0;
  endtask

  // Non-memory instruction: DECODE -> EXEC -> WB -> FETCH
  task automatic run_simple(input string tag,
                            input logic [31:0] w,
                            input logic [31:0] npc,
                            input logic [5:0]  fmt,
                            input logic        we);
    next_pc = npc;
    fetch(w);
    tick();
    check({tag, "_fmt"}, 32'(format), 32'(fmt));
    tick();
    check({tag, "_retire"}, 32'(retire), 32'd1);
    check({tag, "_rdwe"}, 32'(rd_we), 32'(we));
    tick();
    check({tag, "_pc"}, pc, npc);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = '0;
    dmem_valid = 1'b0;
    next_pc = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_fmt", 32'(format), 32'h0);
    check("rst_flags", {29'd0, halt, trap, dmem_req}, 32'h0);
    do_reset();
    check("rst_imem_req", 32'(imem_req), 32'd1);

    // addi: retire 3 cycles after valid
    next_pc = 32'h4;
    fetch(32'h0050_0093);
    check("addi_inst", inst, 32'h0050_0093);
    check("addi_retire_dec", 32'(retire), 32'd0);
    tick();
    check("addi_fmt", 32'(format), 32'h02);
    check("addi_retire_exec", 32'(retire), 32'd0);
    tick();
    check("addi_retire", 32'(retire), 32'd1);
    check("addi_rdwe", 32'(rd_we), 32'd1);
    tick();
    check("addi_pc", pc, 32'h4);
    check("addi_retire_after", 32'(retire), 32'd0);

    // store with two dmem wait cycles
    next_pc = 32'h8;
    fetch(32'h0011_2023);
    tick();
    check("sw_fmt", 32'(format), 32'h04);
    tick();
    check("sw_dreq", 32'(dmem_req), 32'd1);
    check("sw_we", 32'(dmem_we), 32'd1);
    tick();
    tick();
    check("sw_dreq_wait", 32'(dmem_req), 32'd1);
    dmem_valid = 1'b1;
    tick();
    dmem_valid = 1'b0;
    check("sw_retire", 32'(retire), 32'd1);
    check("sw_rdwe", 32'(rd_we), 32'd0);
    check("sw_dreq_wb", 32'(dmem_req), 32'd0);
    tick();
    check("sw_pc", pc, 32'h8);

    // LUI, JAL, BEQ, illegal
    run_simple("lui", 32'h0000_12B7, 32'hC, 6'b010000, 1'b1);
    run_simple("jal", 32'h0080_006F, 32'h14, 6'b100000, 1'b1);
    run_simple("beq", 32'h0000_0463, 32'h1C, 6'b001000, 1'b0);
    next_pc = 32'h20;
    fetch(32'hFFFF_FFFF);
    tick();
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd0);
    check("ill_fmt", 32'(format), 32'h0);
    check("ill_retire", 32'(retire), 32'd0);
    imem_valid = 1'b1;
    tick();
    tick();
    imem_valid = 1'b0;
    check("ill_pc", pc, 32'h1C);
    check("ill_ireq", 32'(imem_req), 32'd0);

    // fetch timeout: 16 cycles without valid
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", 32'(trap), 32'd0);
    check("to_ireq", 32'(imem_req), 32'd1);
    tick();
    check("to_trap", 32'(trap), 32'd1);
    check("to_cause", 32'(trap_cause), 32'd1);
    check("to_ireq_off", 32'(imem_req), 32'd0);

    // valid on 16th wait cycle accepted; then misaligned next PC
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    next_pc = 32'h6;
    fetch(32'h0050_0093);
    check("late_trap", 32'(trap), 32'd0);
    check("late_inst", inst, 32'h0050_0093);
    tick();
    tick();
    check("mis_retire", 32'(retire), 32'd0);
    check("mis_rdwe", 32'(rd_we), 32'd0);
    tick();
    check("mis_trap", 32'(trap), 32'd1);
    check("mis_cause", 32'(trap_cause), 32'd3);
    check("mis_pc", pc, 32'h0);

    // ebreak halts
    do_reset();
    next_pc = 32'h4;
    fetch(32'h0010_0073);
    tick();
    check("ebrk_halt", 32'(halt), 32'd1);
    check("ebrk_trap", 32'(trap), 32'd0);
    check("ebrk_fmt", 32'(format), 32'h0);
    imem_valid = 1'b1;
    dmem_valid = 1'b1;
    tick();
    tick();
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    check("ebrk_strobes",
          {27'd0, imem_req, dmem_req, dmem_we, rd_we, retire},
          32'h0);
    check("ebrk_pc", pc, 32'h0);

    // async reset in the middle of a load
    do_reset();
    next_pc = 32'h4;
    fetch(32'h0000_2083);
    tick();
    check("lw_fmt", 32'(format), 32'h02);
    tick();
    check("lw_dreq", 32'(dmem_req), 32'd1);
    check("lw_we", 32'(dmem_we), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dreq", 32'(dmem_req), 32'd0);
    check("arst_pc", pc, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("arst_rel_pc", pc, 32'h0);
    check("arst_rel_ireq", 32'(imem_req), 32'd1);
    check("arst_rel_inst", inst, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control sequencer for the RV32I hart. It fetches each instruction over the instruction-memory handshake and holds it in an instruction register. It classifies the opcode into the one-hot format vector consumed by the immediate generator and the decoder. It then steps the datapath through execute, memory and writeback, and owns the PC register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT_CYCLES, 16, max consecutive wait cycles on a memory request before trapping; 0 disables the timeout.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
o_pc  output  32  current PC; also the instruction fetch address.
o_imem_req  output  1  instruction fetch request.
i_imem_valid  input  1  fetch data valid; completes the request.
i_imem_rdata  input  32  fetched instruction word.
o_inst  output  32  instruction register.
o_format  output  6  one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J.
o_dmem_req  output  1  data memory request.
o_dmem_we  output  1  store qualifier, valid with o_dmem_req.
i_dmem_valid  input  1  data access complete.
i_next_pc  input  32  next PC computed by the datapath.
o_rd_we  output  1  register file write enable, one-cycle pulse.
o_retire  output  1  instruction retired, one-cycle pulse.
o_halt  output  1  sticky; SYSTEM opcode reached.
o_trap  output  1  sticky; fault detected.
o_trap_cause  output  2  0 illegal opcode, 1 imem timeout, 2 dmem timeout, 3 misaligned next PC.

Behaviour:
- Reset (async, i_rst_n=0):
  - State = FETCH, o_pc = RESET_PC, o_inst = 0, o_format = 0.
  - o_halt, o_trap and o_trap_cause = 0; wait counter = 0.
  - All strobes drop immediately, including mid-MEM.
- Strobe outputs are Moore decodes of the state register only. o_imem_req = (FETCH). o_dmem_req = (MEM).
- States:
  - FETCH: hold req. On i_imem_valid, o_inst <= i_imem_rdata, go to DECODE.
  - DECODE (1 cycle): classify o_inst[6:0] and register o_format at cycle end.
    - 0110011 -> R.
    - 0010011, 0000011, 1100111, 0001111 -> I.
    - 0100011 -> S. 1100011 -> B.
    - 0110111, 0010111 -> U. 1101111 -> J.
    - 1110011 -> HALT, with o_format = 0.
    - Any other value -> TRAP, cause 0, o_format = 0.
    - Otherwise go to EXEC.
  - EXEC (1 cycle): LOAD or STORE -> MEM; all others -> WB.
  - MEM: o_dmem_we = 1 for STORE, 0 for LOAD. On i_dmem_valid -> WB.
  - WB (1 cycle):
    - If i_next_pc[1:0] != 0: TRAP, cause 3; no o_rd_we, no o_retire; o_pc unchanged.
    - Else o_pc <= i_next_pc, o_retire = 1, o_rd_we = 1 for formats R/I/U/J (0 for S/B), then go to FETCH.
  - HALT, TRAP: terminal until reset; strobes 0; o_inst, o_format and o_pc frozen.
- o_format holds its value from EXEC until the next DECODE; its value in FETCH is the previous instruction's format.
- Wait counter:
  - Clears on entry to FETCH or MEM and on valid; increments each wait cycle without valid.
  - Valid in the TIMEOUT_CYCLES-th wait cycle is still accepted.
  - No valid by then -> TRAP with cause 1 (FETCH) or 2 (MEM).
  - Saturates; never wraps.
- Valid inputs outside FETCH/MEM are ignored.
- Latency from valid fetch to retire pulse: 3 cycles non-memory (DECODE, EXEC, WB); 3 + MEM cycles for loads/stores.

Test Plan:
- Reset, imem returns 32'h00500093 (addi) immediately, i_next_pc = 4 -> o_format = 6'b000010 in EXEC; o_rd_we and o_retire pulse 3 cycles after valid; o_pc = 4.
- Store 32'h00112023 with dmem valid after 2 wait cycles -> o_dmem_we = 1 during MEM; o_format = 6'b000100; WB with o_rd_we = 0, o_retire = 1.
- Sequence LUI, JAL, BEQ, 32'hFFFFFFFF -> formats 010000, 100000, 001000; final word gives o_trap = 1, cause 0, no retire.
- Hold i_imem_valid = 0 for 16 cycles (TIMEOUT_CYCLES = 16) -> TRAP with cause 1. Rerun with valid on the 16th wait cycle -> accepted.
- i_next_pc = 32'h6 at WB -> TRAP cause 3, o_pc unchanged. Separately, ebreak 32'h00100073 -> o_halt = 1 and all strobes 0 thereafter.
- Deassert i_rst_n mid-MEM -> o_dmem_req falls without waiting for a clock edge; after release o_pc = RESET_PC and o_imem_req = 1.
